// File: rtl/rv32_mem_pkg.sv
// Shared sizing constants for the RV32 data-memory slice.
package rv32_mem_pkg;

  localparam int DMEM_SIZE = 1024;
  localparam int WORD_W    = 32;
  localparam int ADDR_LSB  = 2;

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the core (master) and the data RAM (slave).
interface data_memory_if;
  import rv32_mem_pkg::*;

  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM: combinational read, synchronous write, and a
// synchronous reset that reloads every word with its own index.
module data_memory
  import rv32_mem_pkg::*;
#(
  parameter int MEM_SIZE = DMEM_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);

  localparam int INDEX_W = $clog2(MEM_SIZE);

  typedef logic [WORD_W-1:0] mem_t [MEM_SIZE];

  function automatic mem_t indexPattern();
    mem_t pattern;
    for (int i = 0; i < MEM_SIZE; i++) begin
      pattern[i] = WORD_W'(i);
    end
    return pattern;
  endfunction

  // The declaration initialiser gives deterministic loads before any store.
  mem_t mem_q = indexPattern();

  logic [INDEX_W-1:0] wordIdx;
  logic               unusedAddrBits;

  // Byte offset and bits above the array depth are dropped, so addresses alias.
  assign wordIdx        = bus.addr[INDEX_W+ADDR_LSB-1:ADDR_LSB];
  assign unusedAddrBits = ^{bus.addr[WORD_W-1:INDEX_W+ADDR_LSB], bus.addr[ADDR_LSB-1:0]};

  assign bus.rdata = mem_q[wordIdx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= WORD_W'(i);
      end
    end else if (bus.we == 1'b1) begin
      mem_q[wordIdx] <= bus.wdata;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: power-up pattern, write timing,
// aliasing, write-enable gating and synchronous reset priority.
module tb_data_memory;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_memory_if dmemBus ();

  data_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (dmemBus.slave)
  );

  // Rising edges land at t = 10, 30, 50 ... leaving time-zero reads edge-free.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    rst           = r;
    dmemBus.we    = w;
    dmemBus.addr  = a;
    dmemBus.wdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expected);
    checks++;
    assert (dmemBus.rdata === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, dmemBus.rdata, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("powerup_0x0", 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h4, 32'h0);
    #1 checkOutput("powerup_0x4", 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0);
    #1 checkOutput("powerup_0x8", 32'h2);
    applyStimulus(1'b0, 1'b0, 32'hFFC, 32'h0);
    #1 checkOutput("powerup_0xFFC", 32'h3FF);

    applyStimulus(1'b0, 1'b1, 32'h0, 32'h1);
    #1 checkOutput("write_before_edge", 32'h0);
    stepEdge();
    checkOutput("write_after_edge", 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h4, 32'h0);
    #1 checkOutput("neighbour_0x4", 32'h1);

    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 32'h11, 32'h0);
    #1 checkOutput("misaligned_0x11", 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h13, 32'h0);
    #1 checkOutput("misaligned_0x13", 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h1010, 32'h0);
    #1 checkOutput("alias_0x1010", 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'hFFFF_F010, 32'h0);
    #1 checkOutput("alias_high_bits", 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h14, 32'h0);
    #1 checkOutput("next_word_0x14", 32'h5);

    applyStimulus(1'b0, 1'b0, 32'h20, 32'hFFFFFFFF);
    repeat (3) stepEdge();
    checkOutput("we_low_0x20", 32'h8);

    applyStimulus(1'b0, 1'b1, 32'h40, 32'hAAAA5555);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
    #1 checkOutput("prereset_0x40", 32'hAAAA5555);
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678);
    #1 checkOutput("rst_before_edge", 32'hAAAA5555);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
    #1 checkOutput("reset_wins_0x40", 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("reset_restores_0x0", 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    #1 checkOutput("reset_restores_0x10", 32'h4);

    applyStimulus(1'b0, 1'b1, 32'h80, 32'h0BADF00D);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 32'h80, 32'h0);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    #1 checkOutput("rst_pulse_between_edges", 32'h0BADF00D);
    stepEdge();
    checkOutput("rst_pulse_after_edge", 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
